// File: rtl/combinator_pkg.sv
// Shared types and width helpers for the N-channel cross-fading combinator.
package combinator_pkg;

    typedef enum logic {
        STEADY = 1'b0,
        FADE   = 1'b1
    } comb_state_t;

    localparam int MAX_CH = 16;

    // alpha spans 0..steps inclusive, so it needs one bit beyond log2(steps)
    function automatic int alpha_w(input int steps);
        return $clog2(steps) + 1;
    endfunction

    function automatic int ch_w(input int n_ch);
        return $clog2((n_ch > MAX_CH) ? MAX_CH : n_ch);
    endfunction

endpackage

// File: rtl/crossfade_sequencer.sv
// Fade control: tracks source/target channels, the fade weight alpha and a
// depth-one queue of select changes that arrive while a fade is running.
module crossfade_sequencer
    import combinator_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int ALPHA_STEPS = 16,
    localparam int CH_W        = ch_w(N_CH),
    localparam int AW          = alpha_w(ALPHA_STEPS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable_3M,
    input  logic [CH_W-1:0] select,
    output logic [CH_W-1:0] cur_ch,
    output logic [CH_W-1:0] tgt_ch,
    output logic [AW-1:0]   alpha,
    output logic            fade_busy
);

    comb_state_t     state, state_n;
    logic [CH_W-1:0] cur_n, tgt_n, pend_ch, pend_n;
    logic [AW-1:0]   alpha_n;
    logic            pend_valid, pv_n;
    logic            sel_ok;

    assign sel_ok = (32'(select) < 32'(N_CH));

    always_comb begin
        state_n = state;
        cur_n   = cur_ch;
        tgt_n   = tgt_ch;
        alpha_n = alpha;
        pv_n    = pend_valid;
        pend_n  = pend_ch;
        case (state)
            STEADY: begin
                if (sel_ok && (select != cur_ch)) begin
                    tgt_n   = select;
                    alpha_n = '0;
                    state_n = FADE;
                end
            end
            FADE: begin
                // Queue update first so a change on the final strobe is seen below
                if (sel_ok && (select != tgt_ch)) begin
                    pv_n   = 1'b1;
                    pend_n = select;
                end else if (select == tgt_ch) begin
                    pv_n = 1'b0;
                end
                if (enable_3M) begin
                    if (alpha < AW'(ALPHA_STEPS)) begin
                        alpha_n = alpha + AW'(1);
                    end else begin
                        cur_n   = tgt_ch;
                        alpha_n = '0;
                        if (pv_n && (pend_n != tgt_ch)) begin
                            tgt_n = pend_n;
                        end else begin
                            state_n = STEADY;
                        end
                        pv_n = 1'b0;
                    end
                end
            end
            default: state_n = STEADY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= STEADY;
            cur_ch     <= '0;
            tgt_ch     <= '0;
            alpha      <= '0;
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            fade_busy  <= 1'b0;
        end else begin
            state      <= state_n;
            cur_ch     <= cur_n;
            tgt_ch     <= tgt_n;
            alpha      <= alpha_n;
            pend_valid <= pv_n;
            pend_ch    <= pend_n;
            fade_busy  <= (state_n == FADE) | pv_n;
        end
    end

endmodule

// File: rtl/multi_channel_combinator.sv
// N-channel combinator: channel muxes plus a two-stage weighted-sum pipeline
// that cross-fades linearly between the source and target channel.
module multi_channel_combinator
    import combinator_pkg::*;
#(
    parameter  int N_CH        = 4,
    parameter  int DATA_W      = 11,
    parameter  int ALPHA_STEPS = 16,
    localparam int FRAC_W      = $clog2(ALPHA_STEPS),
    localparam int CH_W        = ch_w(N_CH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_3M,
    input  logic [CH_W-1:0]        select,
    input  logic [N_CH*DATA_W-1:0] data_in,
    output logic [DATA_W-1:0]      data_output,
    output logic                   data_valid,
    output logic                   fade_busy,
    output logic [CH_W-1:0]        active_ch
);

    localparam int AW    = alpha_w(ALPHA_STEPS);
    localparam int SUM_W = DATA_W + FRAC_W;

    function automatic logic [DATA_W-1:0] trunc_frac(input logic [SUM_W-1:0] s);
        return DATA_W'(s >> FRAC_W);
    endfunction

    logic [CH_W-1:0]   cur_ch, tgt_ch;
    logic [AW-1:0]     alpha, weight_a;
    logic [DATA_W-1:0] ch_samp [N_CH];
    logic [DATA_W-1:0] samp_a, samp_b;
    logic [SUM_W-1:0]  prod_a_p1, prod_b_p1;
    logic              vld_p1;

    crossfade_sequencer #(
        .N_CH        (N_CH),
        .ALPHA_STEPS (ALPHA_STEPS)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .enable_3M (enable_3M),
        .select    (select),
        .cur_ch    (cur_ch),
        .tgt_ch    (tgt_ch),
        .alpha     (alpha),
        .fade_busy (fade_busy)
    );

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_samp[k] = data_in[k*DATA_W +: DATA_W];
    end

    assign samp_a    = ch_samp[cur_ch];
    assign samp_b    = ch_samp[tgt_ch];
    assign weight_a  = AW'(ALPHA_STEPS) - alpha;
    assign active_ch = cur_ch;

    // Stage 1: weighted products, captured on the sample strobe
    always_ff @(posedge clk) begin
        if (enable_3M) begin
            prod_a_p1 <= SUM_W'(weight_a) * SUM_W'(samp_a);
            prod_b_p1 <= SUM_W'(alpha) * SUM_W'(samp_b);
        end
    end

    // Stage 2: sum and drop the fractional bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1      <= 1'b0;
            data_valid  <= 1'b0;
            data_output <= '0;
        end else begin
            vld_p1     <= enable_3M;
            data_valid <= vld_p1;
            if (vld_p1) begin
                data_output <= trunc_frac(prod_a_p1 + prod_b_p1);
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_combinator.sv
// Scoreboard bench for the N-channel combinator: a 4-channel and a 3-channel build.
module tb_multi_channel_combinator;

    typedef struct packed {
        logic [10:0] data;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0, en3 = 1'b0;
    logic [1:0]  sel = '0, sel3 = '0;
    logic [43:0] din = '0;
    logic [32:0] din3 = '0;
    logic [10:0] dout, dout3;
    logic        dval, dval3, busy, busy3;
    logic [1:0]  act, act3;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    exp_t        q_main[$];
    exp_t        q_n3[$];
    exp_t        mon_e, mon_e3;

    multi_channel_combinator dut (
        .clk(clk), .reset(reset), .enable_3M(en), .select(sel), .data_in(din),
        .data_output(dout), .data_valid(dval), .fade_busy(busy), .active_ch(act)
    );

    multi_channel_combinator #(.N_CH(3)) dut3 (
        .clk(clk), .reset(reset), .enable_3M(en3), .select(sel3), .data_in(din3),
        .data_output(dout3), .data_valid(dval3), .fade_busy(busy3), .active_ch(act3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dval) begin
            checks++;
            if (q_main.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_valid got=%0d at cyc %0d", dout, cyc);
            end else begin
                mon_e = q_main.pop_front();
                if (dout !== mon_e.data || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL main_sample got=%0d@%0d want=%0d@%0d", dout, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
        if (dval3) begin
            checks++;
            if (q_n3.size() == 0) begin
                errors++;
                $display("FAIL n3_unexpected_valid got=%0d at cyc %0d", dout3, cyc);
            end else begin
                mon_e3 = q_n3.pop_front();
                if (dout3 !== mon_e3.data || cyc != mon_e3.cyc) begin
                    errors++;
                    $display("FAIL n3_sample got=%0d@%0d want=%0d@%0d", dout3, cyc, mon_e3.data, mon_e3.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
        checks++;
        if (actual !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, actual, want);
        end
    endtask

    // One strobe cycle followed by an idle gap; the expected sample lands two edges later
    task automatic strobe(input bit which, input bit push, input logic [10:0] want);
        exp_t e;
        @(negedge clk);
        if (which) en3 = 1'b1; else en = 1'b1;
        e.data = want;
        e.cyc  = cyc + 2;
        if (push) begin
            if (which) q_n3.push_back(e); else q_main.push_back(e);
        end
        @(negedge clk);
        en  = 1'b0;
        en3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q_main.size() != 0 || q_n3.size() != 0) && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", q_main.size() + q_n3.size(), 0);
    endtask

    task automatic set4(input int v0, input int v1, input int v2, input int v3);
        din = {11'(v3), 11'(v2), 11'(v1), 11'(v0)};
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_output", dout, 0);
        check("rst_data_valid", dval, 0);
        check("rst_fade_busy", busy, 0);
        check("rst_active_ch", act, 0);
        @(negedge clk);
        reset = 1'b1;

        // Steady pass-through of channel 0
        set4(100, 500, 7, 9);
        strobe(0, 1, 11'd100);
        strobe(0, 1, 11'd100);

        // Fade 0->1: 100 + 25*alpha
        @(negedge clk);
        sel = 2'd1;
        @(negedge clk);
        check("fade1_busy_start", busy, 1);
        check("fade1_active_src", act, 0);
        for (int k = 0; k <= 16; k++) strobe(0, 1, 11'(100 + 25 * k));
        repeat (2) @(negedge clk);
        check("fade1_busy_end", busy, 0);
        check("fade1_active_end", act, 1);
        strobe(0, 1, 11'd500);

        // Truncation: 0 -> 1 only reaches 1 at the last step
        set4(100, 0, 1, 9);
        @(negedge clk);
        sel = 2'd2;
        for (int k = 0; k <= 16; k++) strobe(0, 1, (k == 16) ? 11'd1 : 11'd0);

        // Full-scale on both sides stays at 2047
        set4(100, 0, 2047, 2047);
        @(negedge clk);
        sel = 2'd3;
        for (int k = 0; k <= 16; k++) strobe(0, 1, 11'd2047);
        check("full_scale_active", act, 3);
        drain();

        // Fade 3->0, reset arrives at alpha=8 with a sample still in flight
        set4(0, 0, 2047, 1600);
        @(negedge clk);
        sel = 2'd0;
        for (int k = 0; k <= 6; k++) strobe(0, 1, 11'(1600 - 100 * k));
        drain();
        check("pre_reset_out", dout, 1000);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_rst_out", dout, 0);
        check("async_rst_valid", dval, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_active", act, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        set4(321, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        strobe(0, 1, 11'd321);
        drain();

        // Mid-fade requests: 0->1, then 2 then 3 queued, latest wins
        set4(100, 500, 300, 900);
        @(negedge clk);
        sel = 2'd1;
        for (int k = 0; k <= 4; k++) strobe(0, 1, 11'(100 + 25 * k));
        @(negedge clk);
        sel = 2'd2;
        @(negedge clk);
        sel = 2'd3;
        for (int k = 5; k <= 16; k++) begin
            strobe(0, 1, 11'(100 + 25 * k));
            check("queue_busy_hold", busy, 1);
        end
        check("queue_active_mid", act, 1);
        for (int k = 0; k <= 2; k++) strobe(0, 1, 11'(500 + 25 * k));
        // Strobe starvation: alpha must freeze
        repeat (1000) @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_active", act, 1);
        for (int k = 3; k <= 16; k++) strobe(0, 1, 11'(500 + 25 * k));
        repeat (2) @(negedge clk);
        check("queue_active_end", act, 3);
        check("queue_busy_end", busy, 0);

        // 3-channel build: select 3 is out of range everywhere
        din3 = {11'd1234, 11'd850, 11'd50};
        @(negedge clk);
        sel3 = 2'd3;
        repeat (2) @(negedge clk);
        check("n3_steady_busy", busy3, 0);
        check("n3_steady_active", act3, 0);
        strobe(1, 1, 11'd50);
        sel3 = 2'd1;
        for (int k = 0; k <= 3; k++) strobe(1, 1, 11'(50 + 50 * k));
        sel3 = 2'd3;
        for (int k = 4; k <= 16; k++) strobe(1, 1, 11'(50 + 50 * k));
        repeat (2) @(negedge clk);
        check("n3_fade_busy_end", busy3, 0);
        check("n3_fade_active", act3, 1);
        strobe(1, 1, 11'd850);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
